// File: rtl/adc_scan_sched.sv
// adc_scan_sched: periodic scanner for the four PCF8591 ADC channels, driven
// through an external I2C engine, with one-shot host reads that take priority
// between channel reads.
//
// Build option: define ADC_SCAN_AVG_EN to average each new sample with the
// value already held for that channel (rounded, 9-bit sum). Without it, raw
// samples are stored and no averaging logic is built.
//
// Engine handshake: eng_start is a one-cycle request issued only while
// eng_busy=0; eng_ctrl is held from that cycle until the matching eng_done
// pulse, and eng_nack/eng_data are only meaningful in the eng_done cycle.
module adc_scan_sched #(
    parameter int         SCAN_DIV = 50000,
    parameter logic [3:0] CH_MASK  = 4'b1111,
    parameter int         TIMEOUT  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        host_req,
    input  logic [1:0]  host_ch,
    output logic        host_ack,
    output logic        host_valid,
    output logic [7:0]  host_data,
    output logic        eng_start,
    output logic [7:0]  eng_ctrl,
    input  logic        eng_busy,
    input  logic        eng_done,
    input  logic        eng_nack,
    input  logic [7:0]  eng_data,
    output logic [31:0] ch_data,
    output logic [3:0]  ch_valid,
    output logic [7:0]  err_cnt,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] STORE = 2'd3;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             pending;       // a scan round is due
    logic             round_active;  // a round is in progress (may be paused for the host)
    logic [1:0]       scan_ch;       // next channel the round will read
    logic [1:0]       cur_ch;        // channel of the read in flight
    logic             is_host;       // read in flight serves the host
    logic             is_real;       // 0: DUMMY transaction, 1: REAL transaction
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       sample;
    logic [7:0]       store_val;
    logic [2:0]       first_ch;      // {found, channel}
    logic [2:0]       after_ch;      // {found, channel}
    logic [7:0]       err_next;

    // Lowest enabled channel at or above 'from'; MSB flags that one exists.
    function automatic logic [2:0] next_enabled(input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && CH_MASK[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_ch  = next_enabled(3'd0);
    assign after_ch  = next_enabled({1'b0, cur_ch} + 3'd1);
    assign div_wrap  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign err_next  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    assign fsm_state = state;

    // The host is acknowledged in the very cycle IDLE commits to its read.
    assign host_ack  = !rst && (state == IDLE) && host_req;

`ifdef ADC_SCAN_AVG_EN
    logic [8:0] avg_sum;

    // Rounded mean of the held value and the new sample; first sample is raw.
    always_comb begin
        avg_sum   = {1'b0, ch_data[{cur_ch, 3'b000} +: 8]} + {1'b0, sample} + 9'd1;
        store_val = ch_valid[cur_ch] ? 8'(avg_sum >> 1) : sample;
    end
`else
    assign store_val = sample;
`endif

    // Scan-rate divider: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || !en || div_wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Transaction sequencer: IDLE picks the next read, ISSUE/WAIT run the
    // DUMMY and REAL engine transactions, STORE publishes the REAL result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            round_active <= 1'b0;
            scan_ch      <= 2'd0;
            cur_ch       <= 2'd0;
            is_host      <= 1'b0;
            is_real      <= 1'b0;
            tmo_cnt      <= '0;
            sample       <= 8'h00;
            eng_start    <= 1'b0;
            eng_ctrl     <= 8'h40;
            host_valid   <= 1'b0;
            host_data    <= 8'h00;
            ch_data      <= 32'h0;
            ch_valid     <= 4'h0;
            err_cnt      <= 8'h00;
        end else begin
            eng_start  <= 1'b0;
            host_valid <= 1'b0;

            // Wraps during a round collapse into one pending flag.
            if (!en) begin
                pending <= 1'b0;
            end else if (div_wrap) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    is_real <= 1'b0;
                    if (host_req) begin
                        cur_ch   <= host_ch;
                        is_host  <= 1'b1;
                        eng_ctrl <= 8'h40 | {6'd0, host_ch};
                        state    <= ISSUE;
                    end else if (round_active && en) begin
                        cur_ch   <= scan_ch;
                        is_host  <= 1'b0;
                        eng_ctrl <= 8'h40 | {6'd0, scan_ch};
                        state    <= ISSUE;
                    end else if (pending && en && first_ch[2]) begin
                        round_active <= 1'b1;
                        pending      <= div_wrap;
                        scan_ch      <= first_ch[1:0];
                        cur_ch       <= first_ch[1:0];
                        is_host      <= 1'b0;
                        eng_ctrl     <= 8'h40 | {6'd0, first_ch[1:0]};
                        state        <= ISSUE;
                    end else begin
                        // Scan disabled between channels: the round is dropped.
                        round_active <= 1'b0;
                    end
                end

                ISSUE: begin
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (eng_done && !eng_nack) begin
                        if (!is_real) begin
                            // DUMMY data is the previous conversion; discard it.
                            is_real <= 1'b1;
                            state   <= ISSUE;
                        end else begin
                            sample <= eng_data;
                            state  <= STORE;
                        end
                    end else if (eng_done || tmo_cnt == TMO_W'(TIMEOUT)) begin
                        // NACK or timeout: count it and give up on this channel.
                        err_cnt <= err_next;
                        state   <= IDLE;
                        if (!is_host) begin
                            if (after_ch[2] && en) begin
                                scan_ch <= after_ch[1:0];
                            end else begin
                                round_active <= 1'b0;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                STORE: begin
                    ch_data[{cur_ch, 3'b000} +: 8] <= store_val;
                    ch_valid[cur_ch]               <= 1'b1;
                    if (is_host) begin
                        host_valid <= 1'b1;
                        host_data  <= sample;
                    end
                    state <= IDLE;
                    if (!is_host) begin
                        if (after_ch[2] && en) begin
                            scan_ch <= after_ch[1:0];
                        end else begin
                            round_active <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
